// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode 7-segment display.
// Latency: all outputs registered; a LOAD is shown from the next frame boundary (or that same edge).
// Backpressure: none; READY is status only and LOAD is always accepted (last write wins).
// Optional: define LEADING_ZERO_BLANK_EN to keep leading-zero digit slots dark.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] VALUE,
  output logic                    READY,
  output logic [3:0]              BI_DIGIT,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int VAL_W   = 4 * NUM_DIGITS;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [VAL_W-1:0]        disp_q;
  logic [VAL_W-1:0]        pend_q;
  // ready_q low means an update is waiting in pend_q.
  logic                    ready_q;
  logic [3:0]              bi_q;
  logic [NUM_DIGITS-1:0]   an_q;

  logic                    drive_end;
  logic                    commit;
  logic [IDX_W-1:0]        idx_d;
  logic [VAL_W-1:0]        disp_d;
  logic [NUM_DIGITS-1:0]   an_drive;

  // Frame-boundary detection, next digit index and the display value after a possible commit.
  always_comb begin
    drive_end = (state_q == ST_DRIVE) && (cnt_q == DRIVE_LAST);
    commit    = drive_end && (idx_q == IDX_LAST);
    idx_d     = idx_q;
    if (drive_end) begin
      idx_d = commit ? '0 : idx_q + 1'b1;
    end
    disp_d = disp_q;
    if (commit) begin
      // A LOAD landing on the commit edge skips the pending register entirely.
      if (LOAD) begin
        disp_d = VALUE;
      end else if (!ready_q) begin
        disp_d = pend_q;
      end
    end
  end

  // Anode pattern to apply when the current digit enters its drive window.
  always_comb begin
    an_drive        = '1;
    an_drive[idx_q] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // Dark slot when this digit and every higher one are zero; digit 0 always lit.
    if ((idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0)) begin
      an_drive = '1;
    end
`endif
  end

  // Scan FSM, frame buffer and load handshake; every output is a register here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      ready_q <= 1'b1;
      bi_q    <= 4'h0;
      an_q    <= '1;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ST_DRIVE;
            cnt_q   <= '0;
            an_q    <= an_drive;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (drive_end) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            an_q    <= '1;
            // Nibble only moves on entry to BLANK so it is settled before the anode turns on.
            bi_q    <= disp_d[{idx_d, 2'b00} +: 4];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_BLANK;
        end
      endcase

      idx_q  <= idx_d;
      disp_q <= disp_d;

      if (commit) begin
        ready_q <= 1'b1;
      end else if (LOAD) begin
        pend_q  <= VALUE;
        ready_q <= 1'b0;
      end
    end
  end

  assign READY    = ready_q;
  assign BI_DIGIT = bi_q;
  assign AN       = an_q;

endmodule
